morra_scoreboard: RTL

Downstream consumer of the MorraCienese game FSM. Samples its registered ROUND/GAME outputs every clk and keeps per-game round statistics plus running match tallies across games. At game end it latches a result record and offers it on a valid/ready handshake to the reporting/display stage. It shares the START strobe with the game FSM.

---
 rtl/morra_pkg.sv | 34 +++
 rtl/sat_counter.sv | 34 +++
 rtl/morra_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/morra_pkg.sv
// Shared codes for the MorraCienese game FSM and its scoreboard: round/game
// encodings, scoreboard states and result-record field slots.
package morra_pkg;

   typedef enum logic [1:0] {
      R_NONE = 2'b00,
      R_P1   = 2'b01,
      R_P2   = 2'b10,
      R_DRAW = 2'b11
   } round_e;

   typedef enum logic [1:0] {
      G_PLAY = 2'b00,
      G_P1   = 2'b01,
      G_P2   = 2'b10,
      G_TIE  = 2'b11
   } game_e;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_PLAYING = 3'd2,
      S_REPORT  = 3'd3,
      S_DONE    = 3'd4
   } sb_state_e;

   // Result record fields sit in CNT_W-wide slots; offset = slot * CNT_W.
   localparam int unsigned RES_WIN_W    = 2;
   localparam int unsigned RES_DR_SLOT  = 0;
   localparam int unsigned RES_P2_SLOT  = 1;
   localparam int unsigned RES_P1_SLOT  = 2;
   localparam int unsigned RES_WIN_SLOT = 3;

endpackage

// File: rtl/sat_counter.sv
// Registered up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/morra_scoreboard.sv
// Per-game round statistics and cross-game tallies for the Morra game FSM,
// with the final result offered on a valid/ready handshake.
module morra_scoreboard
   import morra_pkg::*;
#(
   parameter int unsigned CNT_W   = 5,
   parameter int unsigned MATCH_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 START,
   input  logic [1:0]           ROUND,
   input  logic [1:0]           GAME,
   output logic [CNT_W-1:0]     P1_WINS,
   output logic [CNT_W-1:0]     P2_WINS,
   output logic [CNT_W-1:0]     DRAWS,
   output logic [CNT_W-1:0]     VOIDS,
   output logic [MATCH_W-1:0]   MATCH_P1,
   output logic [MATCH_W-1:0]   MATCH_P2,
   output logic [MATCH_W-1:0]   MATCH_TIE,
   output logic                 BUSY,
   output logic                 RES_VALID,
   input  logic                 RES_READY,
   output logic [2+3*CNT_W-1:0] RES_DATA,
   output logic                 OVERRUN
);

   localparam int unsigned RES_W = RES_WIN_W + 3 * CNT_W;

   sb_state_e          state_q, state_d;
   logic               res_valid_q, res_valid_d;
   logic [RES_W-1:0]   res_data_q, res_data_d;
   logic               overrun_q, overrun_d;
   logic               busy_q;

   logic clr_game;
   logic inc_p1, inc_p2, inc_dr, inc_void;
   logic inc_m_p1, inc_m_p2, inc_m_tie;

   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      overrun_d   = overrun_q;
      clr_game    = 1'b0;
      inc_p1      = 1'b0;
      inc_p2      = 1'b0;
      inc_dr      = 1'b0;
      inc_void    = 1'b0;
      inc_m_p1    = 1'b0;
      inc_m_p2    = 1'b0;
      inc_m_tie   = 1'b0;

      if (START) begin
         // A same-edge handshake means the record was consumed, not lost.
         clr_game    = 1'b1;
         res_valid_d = 1'b0;
         state_d     = S_ARMED;
         if (res_valid_q && !RES_READY) begin
            overrun_d = 1'b1;
         end
      end else begin
         case (state_q)
            S_IDLE, S_DONE: ;
            S_ARMED: state_d = S_PLAYING;
            S_PLAYING: begin
               if (game_e'(GAME) == G_PLAY) begin
                  case (round_e'(ROUND))
                     R_NONE: inc_void = 1'b1;
                     R_P1:   inc_p1   = 1'b1;
                     R_P2:   inc_p2   = 1'b1;
                     R_DRAW: inc_dr   = 1'b1;
                     default: ;
                  endcase
               end else begin
                  res_data_d[RES_WIN_SLOT*CNT_W +: RES_WIN_W] = GAME;
                  res_data_d[RES_P1_SLOT*CNT_W +: CNT_W]      = P1_WINS;
                  res_data_d[RES_P2_SLOT*CNT_W +: CNT_W]      = P2_WINS;
                  res_data_d[RES_DR_SLOT*CNT_W +: CNT_W]      = DRAWS;
                  res_valid_d = 1'b1;
                  inc_m_p1    = (game_e'(GAME) == G_P1);
                  inc_m_p2    = (game_e'(GAME) == G_P2);
                  inc_m_tie   = (game_e'(GAME) == G_TIE);
                  state_d     = S_REPORT;
               end
            end
            S_REPORT: begin
               if (RES_READY) begin
                  res_valid_d = 1'b0;
                  state_d     = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         overrun_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         overrun_q   <= overrun_d;
         busy_q      <= (state_d == S_ARMED) || (state_d == S_PLAYING);
      end
   end

   sat_counter #(.W(CNT_W)) u_p1_wins (
      .clk(clk), .rst(rst), .clr(clr_game), .inc(inc_p1), .cnt(P1_WINS));
   sat_counter #(.W(CNT_W)) u_p2_wins (
      .clk(clk), .rst(rst), .clr(clr_game), .inc(inc_p2), .cnt(P2_WINS));
   sat_counter #(.W(CNT_W)) u_draws (
      .clk(clk), .rst(rst), .clr(clr_game), .inc(inc_dr), .cnt(DRAWS));
   sat_counter #(.W(CNT_W)) u_voids (
      .clk(clk), .rst(rst), .clr(clr_game), .inc(inc_void), .cnt(VOIDS));

   // Match tallies survive START; only rst clears them.
   sat_counter #(.W(MATCH_W)) u_match_p1 (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(inc_m_p1), .cnt(MATCH_P1));
   sat_counter #(.W(MATCH_W)) u_match_p2 (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(inc_m_p2), .cnt(MATCH_P2));
   sat_counter #(.W(MATCH_W)) u_match_tie (
      .clk(clk), .rst(rst), .clr(1'b0), .inc(inc_m_tie), .cnt(MATCH_TIE));

   assign BUSY      = busy_q;
   assign RES_VALID = res_valid_q;
   assign RES_DATA  = res_data_q;
   assign OVERRUN   = overrun_q;

endmodule
